coin_vend_fsm: RTL and testbench

Parametrised successor to the fixed-price soda machine FSM. It takes CoinValue codes that may stay asserted for any number of cycles and credits each coin once, on release. Price, coin values and drop pulse length are parameters. It dispenses multiple items when credit covers more than one price, refunds on cancel, and counts items sold. It is the top-level vending control block fed by the coin sensor and driving the drop actuator.

---
 rtl/coin_vend_if.sv | 25 ++
 rtl/coin_vend_fsm.sv | 132 +++++++++++++
 tb/tb_coin_vend_fsm.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/coin_vend_if.sv
// Coin-sensor / vend-control bus: the sensor side drives coin and cancel,
// and the vending FSM drives credit, drop, refund and status.
interface coin_vend_if #(
    parameter int unsigned CREDIT_W = 4,
    parameter int unsigned COUNT_W  = 16
);
    logic [1:0]          CoinValue;
    logic                cancel;
    logic [CREDIT_W-1:0] credit;
    logic                drop;
    logic [CREDIT_W-1:0] change;
    logic                change_valid;
    logic [COUNT_W-1:0]  items_sold;
    logic                busy;

    modport master (
        output CoinValue, cancel,
        input  credit, drop, change, change_valid, items_sold, busy
    );

    modport slave (
        input  CoinValue, cancel,
        output credit, drop, change, change_valid, items_sold, busy
    );
endinterface

// File: rtl/coin_vend_fsm.sv
// Vending control FSM: credits each coin once on release, dispenses as many
// items as the credit covers, refunds on cancel and counts items sold.
module coin_vend_fsm #(
    parameter int unsigned PRICE       = 4,
    parameter int unsigned VAL_C       = 1,
    parameter int unsigned VAL_T       = 3,
    parameter int unsigned VAL_P       = 5,
    parameter int unsigned CREDIT_W    = 4,
    parameter int unsigned DROP_CYCLES = 1,
    parameter int unsigned COUNT_W     = 16
) (
    input  logic        clock,
    input  logic        reset,
    coin_vend_if.slave  bus
);
    localparam int unsigned MAX_TV = (VAL_T > VAL_C) ? VAL_T : VAL_C;
    localparam int unsigned MAX_V  = (VAL_P > MAX_TV) ? VAL_P : MAX_TV;
    localparam int unsigned CW1    = CREDIT_W + 1;
    localparam int unsigned DW     = (DROP_CYCLES > 1) ? $clog2(DROP_CYCLES) : 1;
    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam logic [DW-1:0]       DROP_LOAD = DW'(DROP_CYCLES - 1);

    if ((2 ** CREDIT_W) <= (PRICE - 1 + MAX_V)) begin : g_bad_credit_w
        $error("coin_vend_fsm: CREDIT_W too narrow for PRICE and coin values");
    end
    if (PRICE < 1 || DROP_CYCLES < 1) begin : g_bad_params
        $error("coin_vend_fsm: PRICE and DROP_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {S_IDLE, S_HELD, S_VEND, S_GAP, S_REFUND} state_e;

    state_e              state_q, state_d;
    logic [1:0]          code_q, code_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic [DW-1:0]       cnt_q, cnt_d;
    logic [COUNT_W-1:0]  sold_q, sold_d;
    logic [CREDIT_W:0]   sum;

    function automatic logic [CREDIT_W:0] coin_val(input logic [1:0] code);
        case (code)
            2'b01:   coin_val = CW1'(VAL_C);
            2'b10:   coin_val = CW1'(VAL_T);
            2'b11:   coin_val = CW1'(VAL_P);
            default: coin_val = '0;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            code_q   <= '0;
            credit_q <= '0;
            change_q <= '0;
            cnt_q    <= '0;
            sold_q   <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            credit_q <= credit_d;
            change_q <= change_d;
            cnt_q    <= cnt_d;
            sold_q   <= sold_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        credit_d = credit_q;
        change_d = change_q;
        cnt_d    = cnt_q;
        sold_d   = sold_q;
        sum      = {1'b0, credit_q} + coin_val(code_q);
        case (state_q)
            S_IDLE: begin
                if (bus.CoinValue != 2'b00) begin
                    code_d  = bus.CoinValue;
                    state_d = S_HELD;
                end else if (bus.cancel && credit_q != '0) begin
                    change_d = credit_q;
                    credit_d = '0;
                    state_d  = S_REFUND;
                end
            end
            S_HELD: begin
                // Any change of code is a release; a new nonzero code is
                // picked up by IDLE on the following cycle.
                if (bus.CoinValue != code_q) begin
                    if (sum >= {1'b0, PRICE_C}) begin
                        credit_d = CREDIT_W'(sum - {1'b0, PRICE_C});
                        cnt_d    = DROP_LOAD;
                        state_d  = S_VEND;
                        if (sold_q != '1) sold_d = sold_q + 1'b1;
                    end else begin
                        credit_d = CREDIT_W'(sum);
                        state_d  = S_IDLE;
                    end
                end
            end
            S_VEND: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (credit_q >= PRICE_C) begin
                    credit_d = credit_q - PRICE_C;
                    state_d  = S_GAP;
                end else if (bus.CoinValue != 2'b00) begin
                    code_d  = bus.CoinValue;
                    state_d = S_HELD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                cnt_d   = DROP_LOAD;
                state_d = S_VEND;
                if (sold_q != '1) sold_d = sold_q + 1'b1;
            end
            S_REFUND: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.credit       = credit_q;
        bus.drop         = (state_q == S_VEND);
        bus.change       = change_q;
        bus.change_valid = (state_q == S_REFUND);
        bus.items_sold   = sold_q;
        bus.busy         = (state_q != S_IDLE);
    end
endmodule

// File: tb/tb_coin_vend_fsm.sv
// Directed bench for coin_vend_fsm (PRICE 4, coins 1/3/5, DROP_CYCLES 2):
// a vector table stepped one clock per record, plus a bounded drop-count run.
module tb_coin_vend_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    coin_vend_if #(.CREDIT_W(4), .COUNT_W(16)) bus ();

    coin_vend_fsm #(
        .PRICE(4), .VAL_C(1), .VAL_T(3), .VAL_P(5),
        .CREDIT_W(4), .DROP_CYCLES(2), .COUNT_W(16)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus)
    );

    typedef struct {
        logic [1:0] coin;
        logic       cancel;
        logic       rst;
        int         credit;
        int         drop;
        int         cv;
        int         change;
        int         sold;
        int         busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] coin, input logic cancel, input logic r,
                       input int credit, input int drop, input int cv,
                       input int change, input int sold, input int busy);
        vec_t v;
        v.coin = coin; v.cancel = cancel; v.rst = r;
        v.credit = credit; v.drop = drop; v.cv = cv;
        v.change = change; v.sold = sold; v.busy = busy;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] coin, input logic cancel, input logic r);
        bus.CoinValue = coin;
        bus.cancel    = cancel;
        rst           = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int drops;
        bit done;
        bus.CoinValue = 2'b00;
        bus.cancel    = 1'b0;

        //  coin   can   rst   cr dr cv ch sold busy
        add(2'b00, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0);
        // triangle held 5 cycles, credited only on release
        for (int i = 0; i < 5; i++) add(2'b10, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1);
        add(2'b00, 1'b0, 1'b0, 3, 0, 0, 0, 0, 0);
        // credit 3 + pentagon: two items with a gap cycle between
        add(2'b11, 1'b0, 1'b0, 3, 0, 0, 0, 0, 1);
        add(2'b11, 1'b0, 1'b0, 3, 0, 0, 0, 0, 1);
        add(2'b00, 1'b0, 1'b0, 4, 1, 0, 0, 1, 1);
        add(2'b00, 1'b0, 1'b0, 4, 1, 0, 0, 1, 1);
        add(2'b00, 1'b0, 1'b0, 0, 0, 0, 0, 1, 1);
        add(2'b00, 1'b0, 1'b0, 0, 1, 0, 0, 2, 1);
        add(2'b00, 1'b0, 1'b0, 0, 1, 0, 0, 2, 1);
        add(2'b00, 1'b0, 1'b0, 0, 0, 0, 0, 2, 0);
        // circle switched straight to triangle
        add(2'b01, 1'b0, 1'b0, 0, 0, 0, 0, 2, 1);
        add(2'b10, 1'b0, 1'b0, 1, 0, 0, 0, 2, 0);
        add(2'b10, 1'b0, 1'b0, 1, 0, 0, 0, 2, 1);
        add(2'b00, 1'b0, 1'b0, 0, 1, 0, 0, 3, 1);
        add(2'b00, 1'b0, 1'b0, 0, 1, 0, 0, 3, 1);
        add(2'b00, 1'b0, 1'b0, 0, 0, 0, 0, 3, 0);
        // build credit 2, then refund
        add(2'b01, 1'b0, 1'b0, 0, 0, 0, 0, 3, 1);
        add(2'b00, 1'b0, 1'b0, 1, 0, 0, 0, 3, 0);
        add(2'b01, 1'b0, 1'b0, 1, 0, 0, 0, 3, 1);
        add(2'b00, 1'b0, 1'b0, 2, 0, 0, 0, 3, 0);
        add(2'b00, 1'b1, 1'b0, 0, 0, 1, 2, 3, 1);
        add(2'b00, 1'b1, 1'b0, 0, 0, 0, 2, 3, 0);
        add(2'b00, 1'b1, 1'b0, 0, 0, 0, 2, 3, 0);
        add(2'b00, 1'b0, 1'b0, 0, 0, 0, 2, 3, 0);
        // coin and cancel together: coin wins
        add(2'b01, 1'b0, 1'b0, 0, 0, 0, 2, 3, 1);
        add(2'b00, 1'b0, 1'b0, 1, 0, 0, 2, 3, 0);
        add(2'b01, 1'b1, 1'b0, 1, 0, 0, 2, 3, 1);
        add(2'b00, 1'b0, 1'b0, 2, 0, 0, 2, 3, 0);
        // circle pulsed inside VEND is lost
        add(2'b10, 1'b0, 1'b0, 2, 0, 0, 2, 3, 1);
        add(2'b00, 1'b0, 1'b0, 1, 1, 0, 2, 4, 1);
        add(2'b01, 1'b0, 1'b0, 1, 1, 0, 2, 4, 1);
        add(2'b00, 1'b0, 1'b0, 1, 0, 0, 2, 4, 0);
        // triangle still held at VEND exit is credited on release
        add(2'b10, 1'b0, 1'b0, 1, 0, 0, 2, 4, 1);
        add(2'b00, 1'b0, 1'b0, 0, 1, 0, 2, 5, 1);
        add(2'b10, 1'b0, 1'b0, 0, 1, 0, 2, 5, 1);
        add(2'b10, 1'b0, 1'b0, 0, 0, 0, 2, 5, 1);
        add(2'b10, 1'b0, 1'b0, 0, 0, 0, 2, 5, 1);
        add(2'b00, 1'b0, 1'b0, 3, 0, 0, 2, 5, 0);
        // reset during the second drop pulse
        add(2'b11, 1'b0, 1'b0, 3, 0, 0, 2, 5, 1);
        add(2'b00, 1'b0, 1'b0, 4, 1, 0, 2, 6, 1);
        add(2'b00, 1'b0, 1'b0, 4, 1, 0, 2, 6, 1);
        add(2'b00, 1'b0, 1'b0, 0, 0, 0, 2, 6, 1);
        add(2'b00, 1'b0, 1'b0, 0, 1, 0, 2, 7, 1);
        add(2'b00, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0);

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            step(vecs[i].coin, vecs[i].cancel, vecs[i].rst);
            chk("credit",       i, int'(bus.credit),       vecs[i].credit);
            chk("drop",         i, int'(bus.drop),         vecs[i].drop);
            chk("change_valid", i, int'(bus.change_valid), vecs[i].cv);
            chk("change",       i, int'(bus.change),       vecs[i].change);
            chk("items_sold",   i, int'(bus.items_sold),   vecs[i].sold);
            chk("busy",         i, int'(bus.busy),         vecs[i].busy);
        end

        // pentagon from zero: one item of exactly two drop cycles, credit 1 left
        step(2'b11, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        drops = 0;
        done  = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (bus.drop) drops++;
            if (!bus.busy) done = 1'b1;
            else step(2'b00, 1'b0, 1'b0);
        end
        chk("vend_timeout", 0, int'(done), 1);
        chk("drop_cycles",  0, drops, 2);
        chk("left_credit",  0, int'(bus.credit), 1);
        chk("sold_after",   0, int'(bus.items_sold), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
